// File: rtl/analog_op_sched_if.sv
// analog_op_sched_if: request/grant/completion bundle between analog requesters and the scheduler.
interface analog_op_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] delay_cfg;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic [ID_W-1:0]          active_id;
    modport master (output req, delay_cfg, input grant, done, busy, active_id);
    modport slave  (input req, delay_cfg, output grant, done, busy, active_id);
endinterface

// File: rtl/analog_op_sched.sv
// analog_op_sched: arbitrates analog operations onto one shared countdown timer.
// Define ANALOG_OP_SCHED_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module analog_op_sched #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16,
    parameter int ID_W    = 2
) (
    input logic              clk,
    input logic              rst,
    analog_op_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cfg_w;
    logic [NUM_REQ-1:0] grant_q, grant_d, done_q, done_d;
    logic [ID_W-1:0]    id_q, id_d, win;
`ifdef ANALOG_OP_SCHED_RR_EN
    logic [ID_W-1:0]    ptr_q, ptr_d;
    int                 j;
    always_comb begin
        win = '0;
        j = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(ptr_q) + i;
            j = (j >= NUM_REQ) ? j - NUM_REQ : j;
            if (bus.req[j]) win = ID_W'(j);
        end
    end
`else
    always_comb begin
        win = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (bus.req[i]) win = ID_W'(i);
    end
`endif
    assign cfg_w = bus.delay_cfg[int'(win)*CNT_W +: CNT_W];
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        done_d  = '0;
        id_d    = id_q;
`ifdef ANALOG_OP_SCHED_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: if (|bus.req) begin
                state_d = RUN;
                grant_d = NUM_REQ'(1) << win;
                id_d    = win;
                cnt_d   = (cfg_w == '0) ? CNT_W'(1) : cfg_w;
`ifdef ANALOG_OP_SCHED_RR_EN
                ptr_d   = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
`endif
            end
            RUN: begin
                // abandon takes precedence over completion, even on the last count
                if (!bus.req[id_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    done_d  = grant_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            id_q    <= '0;
`ifdef ANALOG_OP_SCHED_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            id_q    <= id_d;
`ifdef ANALOG_OP_SCHED_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end
    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.busy      = state_q != IDLE;
    assign bus.active_id = id_q;
endmodule

// File: tb/tb_analog_op_sched.sv
// tb_analog_op_sched: scoreboard bench; expected completions queued at stimulus, checked on done.
module tb_analog_op_sched;
    localparam int N = 4;
    localparam int CW = 16;
    typedef struct {int id; int d;} exp_t;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   gstart = 0;
    logic [N-1:0] prev_g = '0;
    exp_t sb[$];
    exp_t e;
    analog_op_sched_if #(.NUM_REQ(N), .CNT_W(CW), .ID_W(2)) ifc();
    analog_op_sched #(.NUM_REQ(N), .CNT_W(CW), .ID_W(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    task automatic set_dly(input int w, input int d);
        ifc.delay_cfg[w*CW +: CW] = CW'(d);
    endtask
    task automatic wait_done(input int w);
        int n;
        n = 0;
        while (ifc.done[w] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("done_seen_%0d", w), n < 400, 1);
    endtask
    always @(negedge clk) begin
        if (ifc.grant != '0 && prev_g == '0) gstart = cyc;
        prev_g = ifc.grant;
        if (ifc.done != '0) begin
            if (sb.size() == 0) check("sb_underflow", 1, 0);
            else begin
                e = sb.pop_front();
                check("done_id", ifc.active_id, e.id);
                check("done_lat", cyc - gstart, e.d);
                check("done_grant", ifc.done, ifc.grant);
            end
        end
    end
    initial begin
        int ord[$];
        bit rr[$];
        rst = 1'b1;
        ifc.req = '0;
        ifc.delay_cfg = '0;
        repeat (2) @(negedge clk);
        check("rst_grant", ifc.grant, 0);
        check("rst_done", ifc.done, 0);
        check("rst_busy", ifc.busy, 0);
        check("rst_id", ifc.active_id, 0);
        rst = 1'b0;
        @(negedge clk);
        // single request, delay 5
        set_dly(2, 5);
        ifc.req[2] = 1'b1;
        sb.push_back('{2, 5});
        @(negedge clk);
        check("single_grant", ifc.grant, 4'b0100);
        check("single_busy", ifc.busy, 1);
        check("single_id", ifc.active_id, 2);
        wait_done(2);
        ifc.req[2] = 1'b0;
        @(negedge clk);
        check("single_grant_off", ifc.grant, 0);
        check("single_busy_off", ifc.busy, 0);
        check("single_id_hold", ifc.active_id, 2);
        // zero delay behaves as one
        set_dly(0, 0);
        ifc.req[0] = 1'b1;
        sb.push_back('{0, 1});
        @(negedge clk);
        check("zero_grant", ifc.grant, 4'b0001);
        @(negedge clk);
        check("zero_done", ifc.done, 4'b0001);
        wait_done(0);
        ifc.req[0] = 1'b0;
        @(negedge clk);
        // contention from a freshly reset pointer
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_dly(i, 3);
`ifdef ANALOG_OP_SCHED_RR_EN
        ord = '{0, 1, 2, 3};
        rr = '{0, 0, 0, 0};
`else
        ord = '{0, 0, 0, 1, 2, 3};
        rr = '{1, 1, 0, 0, 0, 0};
`endif
        foreach (ord[k]) sb.push_back('{ord[k], 3});
        ifc.req = 4'b1111;
        foreach (ord[k]) begin
            wait_done(ord[k]);
            ifc.req[ord[k]] = 1'b0;
            if (rr[k]) begin
                @(negedge clk);
                ifc.req[ord[k]] = 1'b1;
            end
        end
        @(negedge clk);
        // abandon of a long operation, pending requester 3 follows
        set_dly(1, 100);
        set_dly(3, 4);
        ifc.req[1] = 1'b1;
        @(negedge clk);
        check("ab_grant", ifc.grant, 4'b0010);
        ifc.req[3] = 1'b1;
        sb.push_back('{3, 4});
        repeat (19) @(negedge clk);
        ifc.req[1] = 1'b0;
        @(negedge clk);
        check("ab_grant_off", ifc.grant, 0);
        check("ab_busy_off", ifc.busy, 0);
        check("ab_no_done", ifc.done, 0);
        @(negedge clk);
        check("ab_next_grant", ifc.grant, 4'b1000);
        wait_done(3);
        ifc.req[3] = 1'b0;
        @(negedge clk);
        // reset mid-run with request held through it
        set_dly(2, 6);
        ifc.req[2] = 1'b1;
        sb.push_back('{2, 6});
        @(negedge clk);
        check("mr_grant", ifc.grant, 4'b0100);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mr_grant_rst", ifc.grant, 0);
        check("mr_done_rst", ifc.done, 0);
        check("mr_busy_rst", ifc.busy, 0);
        check("mr_id_rst", ifc.active_id, 0);
        rst = 1'b0;
        @(negedge clk);
        check("mr_regrant", ifc.grant, 4'b0100);
        wait_done(2);
        ifc.req[2] = 1'b0;
        @(negedge clk);
        // delay change during run is ignored
        set_dly(1, 8);
        ifc.req[1] = 1'b1;
        sb.push_back('{1, 8});
        @(negedge clk);
        check("dc_grant", ifc.grant, 4'b0010);
        repeat (3) @(negedge clk);
        set_dly(1, 2);
        wait_done(1);
        ifc.req[1] = 1'b0;
        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
